// File: rtl/dir_cond_pkg.sv
// Shared types for the direction-switch conditioning path.
package dir_cond_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } dbnc_state_t;

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser for an asynchronous level; resets to a configurable level.
module sync_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] flops;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flops <= {STAGES{RESET_LEVEL}};
    else        flops <= {flops[STAGES-2:0], d};
  end

  assign q = flops[STAGES-1];

endmodule

// File: rtl/direction_debouncer.sv
// Synchronises and debounces the count-direction switch; emits a clean level,
// one-cycle rise/fall strobes and a busy flag while a change is being qualified.
module direction_debouncer
  import dir_cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1_000_000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic data_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int               CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam dbnc_state_t      RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic             sync_q;
  dbnc_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             data_nxt, rise_nxt, fall_nxt;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_in),
    .q     (sync_q)
  );

  // Any reversion during a WAIT aborts; only the terminal count commits the level.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sync_q) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync_q) begin
          state_nxt = STABLE_LO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HI;
          data_nxt  = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!sync_q) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (sync_q) begin
          state_nxt = STABLE_HI;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LO;
          data_nxt  = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RESET_STATE;
      cnt        <= '0;
      data_out   <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      data_out   <= data_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      busy       <= (state == WAIT_HI) || (state == WAIT_LO);
    end
  end

endmodule

// File: tb/tb_direction_debouncer.sv
// Directed bench for direction_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_direction_debouncer;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic sw_in = 1'b1;
  logic data_out, rise_pulse, fall_pulse, busy;
  logic [3:0] outs;

  int errors = 0;
  int checks = 0;

  direction_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_LEVEL     (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_in      (sw_in),
    .data_out   (data_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  assign outs = {data_out, rise_pulse, fall_pulse, busy};

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: {data,rise,fall,busy} got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sw_bits[k] is driven before edge k; exp_bits nibble k is the output after edge k.
  task automatic run_vec(input string tag, input int n, input logic [31:0] sw_bits,
                         input logic [127:0] exp_bits);
    for (int k = 0; k < n; k++) begin
      sw_in = sw_bits[k];
      tick();
      check($sformatf("%s[%0d]", tag, k), outs, exp_bits[4*k +: 4]);
    end
  endtask

  initial begin
    // Reset held with the switch high: everything quiet.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset[%0d]", i), outs, 4'b0000);
    end
    reset = 1'b1;
    sw_in = 1'b0;
    run_vec("idle", 5, 32'h0, 128'h0);

    // Clean 0->1: busy from E+3, rise+data at E+6, busy clears at E+7.
    run_vec("rise", 9, 32'h1FF, 128'h88D111000);

    // Clean 1->0: fall+data low at E+6.
    run_vec("fall", 9, 32'h0, 128'h003999888);

    // Two-cycle glitch: busy pulses, no level change.
    run_vec("glitch", 7, 32'h3, 128'h0011000);

    // Bounce 1,0,1,0 then held 1: single rise 6 edges after the last 0->1 sample.
    run_vec("bounce", 12, 32'hFF5, 128'h8D1110101000);

    // Back to low for the reset test.
    run_vec("fall2", 9, 32'h0, 128'h003999888);

    // Enter WAIT_HI, then reset asynchronously between edges.
    run_vec("pre_rst", 4, 32'hF, 128'h1000);
    reset = 1'b0;
    #2;
    check("rst_async", outs, 4'b0000);
    tick();
    check("rst_hold0", outs, 4'b0000);
    tick();
    check("rst_hold1", outs, 4'b0000);
    reset = 1'b1;

    // Full qualification required again after release.
    run_vec("requal", 9, 32'h1FF, 128'h88D111000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
